// File: rtl/secure_access_ctrl.sv
// secure_access_ctrl: key-gated read/write initiator into a single-port synchronous memory with failure lockout
//   req_*     : valid/ready request in (write flag, address, write data, access key)
//   rsp_*     : valid/ready response out (read data, error code 00 OK / 01 KEY_FAIL / 10 LOCKED)
//   mem_*     : single-cycle memory strobe out, read data back one cycle after mem_en
//   locked    : lockout window active
//   fail_cnt  : consecutive key-failure count
module secure_access_ctrl #(
   parameter int          ADDR_W      = 10,
   parameter int          DATA_W      = 32,
   parameter logic [15:0] KEY         = 16'h0032,
   parameter int          PROT_BASE   = 128,
   parameter int          MAX_FAIL    = 3,
   parameter int          LOCK_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [15:0]       req_key,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              locked,
   output logic [1:0]        fail_cnt
);
   localparam int CW = $clog2(LOCK_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, DECIDE, MEM, WAIT, RESP} state_t;
   state_t            r_state;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [15:0]       r_key;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic [1:0]        r_rsp_err;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [1:0]        r_fail_cnt;
   logic [CW-1:0]     r_lock_cnt;
   logic              w_prot;
   logic              w_key_bad;
   logic              w_locked;
   logic [1:0]        w_fail_nxt;
   assign w_prot     = r_addr > ADDR_W'(PROT_BASE);
   assign w_key_bad  = r_key != KEY;
   assign w_locked   = r_lock_cnt != '0;
   assign w_fail_nxt = r_fail_cnt + 2'd1;
   assign req_ready  = r_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_rdata  = r_rsp_rdata;
   assign rsp_err    = r_rsp_err;
   assign mem_en     = r_mem_en;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign locked     = w_locked;
   assign fail_cnt   = r_fail_cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_key       <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 2'b00;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_fail_cnt  <= 2'd0;
         r_lock_cnt  <= '0;
      end else begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         // lockout timer runs regardless of state; a reload in DECIDE below overrides this
         if (w_locked) r_lock_cnt <= r_lock_cnt - CW'(1);
         case (r_state)
            IDLE: begin
               r_req_ready <= 1'b1;
               if (req_valid && r_req_ready) begin
                  r_write     <= req_write;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_key       <= req_key;
                  r_req_ready <= 1'b0;
                  r_state     <= DECIDE;
               end
            end
            DECIDE: begin
               if (w_locked) begin
                  r_rsp_err   <= 2'b10;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else if (w_prot && w_key_bad) begin
                  r_rsp_err   <= 2'b01;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
                  if (w_fail_nxt == 2'(MAX_FAIL)) begin
                     r_lock_cnt <= CW'(LOCK_CYCLES);
                     r_fail_cnt <= 2'd0;
                  end else r_fail_cnt <= w_fail_nxt;
               end else begin
                  if (w_prot) r_fail_cnt <= 2'd0;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= r_write;
                  r_mem_addr  <= r_addr;
                  r_mem_wdata <= r_wdata;
                  r_state     <= MEM;
               end
            end
            MEM: begin
               r_rsp_valid <= r_write;
               r_state     <= r_write ? RESP : WAIT;
            end
            WAIT: begin
               r_rsp_rdata <= mem_rdata;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  // clearing data/err here keeps rdata at 0 for the next write or error response
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 2'b00;
                  r_req_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/secure_access_ctrl.md
Name: secure_access_ctrl

Overview:
Initiator-side access controller that issues key-gated reads and writes into the key-protected memory.
Accepts transfer requests on a valid/ready interface and checks the access key for the protected region. It then drives a single-port synchronous memory and returns a response with an error code.
Repeated key failures trigger a timed lockout.

Parameters:
ADDR_W, 10, address width
DATA_W, 32, data width
KEY, 16'h0032, access key required for protected addresses
PROT_BASE, 128, addresses strictly greater than this are protected
MAX_FAIL, 3, consecutive key failures that trigger lockout
LOCK_CYCLES, 16, lockout duration in clk cycles

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  target address
req_wdata  in  DATA_W  write data
req_key  in  16  access key presented with the request
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  2  00 OK, 01 KEY_FAIL, 10 LOCKED
mem_en  out  1  single-cycle memory access strobe
mem_we  out  1  write enable, valid with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid the cycle after mem_en
locked  out  1  lockout active
fail_cnt  out  2  consecutive key-failure count

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - All outputs 0, including req_ready; fail_cnt=0; lock counter=0.
  - Reset mid-transaction aborts it: no mem_en and no response afterwards.
- FSM states are IDLE, DECIDE, MEM, WAIT and RESP.
- IDLE:
  - req_ready=1 (0 while rst high).
  - On handshake, register write, addr, wdata and key, then go to DECIDE.
- DECIDE (req_ready=0). Priority order:
  1. locked=1 -> RESP with err=10; fail_cnt unchanged.
  2. Protected (addr > PROT_BASE) and key != KEY -> RESP with err=01; fail_cnt+1. If the new count equals MAX_FAIL, load the lock counter with LOCK_CYCLES and clear fail_cnt to 0.
  3. Otherwise -> MEM. A protected access with the correct key clears fail_cnt. Unprotected accesses leave fail_cnt unchanged.
- MEM:
  - mem_en=1 for exactly one cycle, with mem_we=write and mem_addr/mem_wdata from the registered request.
  - Write -> RESP. Read -> WAIT.
- WAIT: capture mem_rdata into rsp_rdata, then go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err are held stable until rsp_ready.
  - On handshake, clear rsp_valid and go to IDLE.
  - Back-to-back: the next request can be accepted the cycle after the response handshake.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside MEM.
- Latency, from the accept cycle T to the first rsp_valid cycle:
  - write OK: T+3
  - read OK: T+4
  - error: T+2
- Lock counter:
  - Decrements every cycle while nonzero, independent of FSM state.
  - locked = (counter != 0).
  - The load in DECIDE takes priority over the decrement.
  - locked rises the cycle after the failing DECIDE and stays high for exactly LOCK_CYCLES cycles.
- Address boundary: addr == PROT_BASE is unprotected; PROT_BASE+1 is protected.
- Only the key of the current request is checked. There is no key persistence across requests.
- A request arriving while in LOCK is still accepted and answered with err=10. It never produces mem_en.

Test Plan:
1. Write addr 100, key 0x0000, data 0xDEADBEEF -> mem_en=mem_we=1 at T+2 with addr 100 and data 0xDEADBEEF; rsp_valid at T+3 with err 00 and rdata 0.
2. Read addr 200, key 0x0032, memory returns 0x12345678 -> rsp at T+4 with rdata 0x12345678 and err 00. Read addr 128, key 0 -> err 00 (boundary unprotected). Read addr 129, key 0 -> err 01, no mem_en.
3. Three writes to addr 300 with key 0x0031:
   - Each gets err 01 at T+2; fail_cnt goes 1, 2, 0.
   - locked is high for exactly 16 cycles after the third; no mem_en at any point.
   - A read of addr 5 during lockout -> err 10.
   - After expiry, a write to addr 300 with key 0x0032 -> err 00.
4. Two bad-key requests, then a good protected request -> fail_cnt returns to 0. Two further bad keys -> no lockout (fail_cnt=2).
5. Hold rsp_ready=0 for 5 cycles on a read response -> rsp_valid, rdata and err stay stable, req_ready stays 0, and the next req_valid is not accepted until the handshake completes.
6. Assert rst during MEM and again during WAIT -> all outputs 0 asynchronously, no response issued, fail_cnt/locked cleared, and req_ready=1 the first cycle after release.
